timer_intr_ctrl: RTL and testbench

//  Memory-mapped timer/interrupt responder on the processor data bus (rd_en/wr_en/addr/wdata/mem_mode).

---
 rtl/intr_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 27 ++
 rtl/timer_intr_ctrl.sv | 145 ++++++++++++++
 tb/tb_timer_intr_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the timer/interrupt responder: register map offsets,
// CTRL/PEND bit positions and the request-tracking state encoding.
package intr_pkg;

    localparam logic [4:0] OFF_MTIME_LO = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI = 5'h04;
    localparam logic [4:0] OFF_CMP_LO   = 5'h08;
    localparam logic [4:0] OFF_CMP_HI   = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;
    localparam logic [4:0] OFF_PEND     = 5'h14;

    localparam int CTRL_TIE = 0;
    localparam int CTRL_EIE = 1;
    localparam int CTRL_RUN = 2;
    localparam int PEND_TIP = 0;
    localparam int PEND_EIP = 1;

    localparam logic [2:0] MODE_WORD = 3'b010;

    typedef enum logic [2:0] {IDLE, T_PEND, E_PEND, T_SVC, E_SVC} intr_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle pulse
// on each rising edge of the synchronised value.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/timer_intr_ctrl.sv
// Memory-mapped 64-bit machine timer plus one external interrupt line, with a
// small FSM that tracks a single request from pending through trap to mret.
module timer_intr_ctrl
    import intr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          PRESCALE    = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  mem_mode,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        ext_irq,
    input  logic        intr_ack,
    input  logic        is_mret,
    output logic        t_intr,
    output logic        e_intr
);

    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

    logic [31:0]   off;
    logic [4:0]    woff;
    logic          wr_hit;
    logic [63:0]   mtime;
    logic [63:0]   cmp;
    logic [2:0]    ctrl;
    logic          eip;
    logic          tip;
    logic [PW-1:0] presc;
    logic          tick;
    logic          irq_rise;
    logic          w1c_eip;
    logic          treq;
    logic          ereq;
    intr_state_t   state, state_nxt;

    // Subtraction keeps the window correct even if BASE_ADDR is not 32-byte aligned.
    assign off    = addr - BASE_ADDR;
    assign woff   = off[4:0];
    assign hit    = (off[31:5] == 27'd0) && (addr[1:0] == 2'b00) && (mem_mode == MODE_WORD);
    assign wr_hit = hit & wr_en;

    assign tick    = ctrl[CTRL_RUN] && (presc == PRESC_MAX);
    assign w1c_eip = wr_hit && (woff == OFF_PEND) && wdata[PEND_EIP];
    assign treq    = tip & ctrl[CTRL_TIE];
    assign ereq    = eip & ctrl[CTRL_EIE];

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ext_irq),
        .rise (irq_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (ctrl[CTRL_RUN]) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // A bus write to either MTIME half overrides that cycle's increment entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_hit && woff == OFF_MTIME_LO) begin
            mtime[31:0] <= wdata;
        end else if (wr_hit && woff == OFF_MTIME_HI) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp  <= '1;
            ctrl <= '0;
            eip  <= 1'b0;
            tip  <= 1'b0;
        end else begin
            if (wr_hit && woff == OFF_CMP_LO) cmp[31:0]  <= wdata;
            if (wr_hit && woff == OFF_CMP_HI) cmp[63:32] <= wdata;
            if (wr_hit && woff == OFF_CTRL)   ctrl       <= wdata[2:0];
            tip <= (mtime >= cmp);
            if (irq_rise)     eip <= 1'b1;
            else if (w1c_eip) eip <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit && rd_en) begin
            case (woff)
                OFF_MTIME_LO: rdata = mtime[31:0];
                OFF_MTIME_HI: rdata = mtime[63:32];
                OFF_CMP_LO:   rdata = cmp[31:0];
                OFF_CMP_HI:   rdata = cmp[63:32];
                OFF_CTRL:     rdata = {29'd0, ctrl};
                OFF_PEND:     rdata = {30'd0, eip, tip};
                default:      rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (treq)      state_nxt = T_PEND;
                else if (ereq) state_nxt = E_PEND;
            end
            T_PEND: begin
                if (intr_ack)   state_nxt = T_SVC;
                else if (!treq) state_nxt = IDLE;
            end
            E_PEND: begin
                if (intr_ack)   state_nxt = E_SVC;
                else if (!ereq) state_nxt = IDLE;
            end
            T_SVC, E_SVC: begin
                if (is_mret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign t_intr = (state == T_PEND);
    assign e_intr = (state == E_PEND);

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Directed plus randomized bench for timer_intr_ctrl against a cycle-level
// behavioural model built from the register map and request rules.
module tb_timer_intr_ctrl;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          P    = 1;
    localparam int          S    = 2;

    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en, ext_irq, intr_ack, is_mret;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  mem_mode;
    logic        hit, t_intr, e_intr;

    int n_checks = 0;
    int n_fail   = 0;

    timer_intr_ctrl #(.BASE_ADDR(BASE), .PRESCALE(P), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .mem_mode(mem_mode), .rdata(rdata), .hit(hit),
        .ext_irq(ext_irq), .intr_ack(intr_ack), .is_mret(is_mret),
        .t_intr(t_intr), .e_intr(e_intr)
    );

    always #5 clk = ~clk;

    // model state; phase: 0 idle, 1 timer pending, 2 ext pending, 3 timer svc, 4 ext svc
    logic [63:0] m_time, m_cmp;
    bit          m_run, m_eie, m_tie, m_eip, m_tip;
    int          m_cnt, m_phase;
    bit          hist [0:S];
    bit          irq_lvl;
    logic [31:0] last_rdata;
    logic        last_hit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a, input logic [2:0] md);
        logic [31:0] o;
        o = a - BASE;
        return (o < 32) && (a[1:0] == 2'b00) && (md == 3'b010);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        case (o)
            32'h00:  return m_time[31:0];
            32'h04:  return m_time[63:32];
            32'h08:  return m_cmp[31:0];
            32'h0C:  return m_cmp[63:32];
            32'h10:  return {29'd0, m_run, m_eie, m_tie};
            32'h14:  return {30'd0, m_eip, m_tip};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_time = 64'd0; m_cmp = '1; m_run = 0; m_eie = 0; m_tie = 0;
        m_eip = 0; m_tip = 0; m_cnt = 0; m_phase = 0;
        for (int i = 0; i <= S; i++) hist[i] = 0;
    endtask

    task automatic m_step(input bit w, input logic [31:0] a, d, input logic [2:0] md,
                          input bit ack, mret, rs);
        bit treq, ereq, rise, tick, wh, ntip;
        logic [31:0] o;
        if (rs) begin
            m_reset();
            return;
        end
        wh   = m_hit(a, md) && w;
        o    = a - BASE;
        treq = m_tip && m_tie;
        ereq = m_eip && m_eie;
        case (m_phase)
            0: m_phase = treq ? 1 : (ereq ? 2 : 0);
            1: m_phase = ack ? 3 : (treq ? 1 : 0);
            2: m_phase = ack ? 4 : (ereq ? 2 : 0);
            default: if (mret) m_phase = 0;
        endcase
        rise = hist[S-1] && !hist[S];
        tick = m_run && (m_cnt == P - 1);
        ntip = (m_time >= m_cmp);
        if (m_run) m_cnt = tick ? 0 : m_cnt + 1;
        if (wh && o == 32'h00)      m_time[31:0]  = d;
        else if (wh && o == 32'h04) m_time[63:32] = d;
        else if (tick)              m_time        = m_time + 64'd1;
        if (wh && o == 32'h08) m_cmp[31:0]  = d;
        if (wh && o == 32'h0C) m_cmp[63:32] = d;
        if (wh && o == 32'h10) {m_run, m_eie, m_tie} = d[2:0];
        if (rise) m_eip = 1;
        else if (wh && o == 32'h14 && d[1]) m_eip = 0;
        m_tip = ntip;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = irq_lvl;
    endtask

    task automatic cyc(input bit r, w, input logic [31:0] a, d, input logic [2:0] md,
                       input bit ack, mret, rs);
        bit eh;
        @(negedge clk);
        rd_en = r; wr_en = w; addr = a; wdata = d; mem_mode = md;
        intr_ack = ack; is_mret = mret; rst = rs; ext_irq = irq_lvl;
        #1;
        eh = m_hit(a, md);
        last_rdata = rdata;
        last_hit   = hit;
        check("hit", hit, eh);
        check("rdata", rdata, (eh && r) ? m_read(a) : 32'd0);
        @(posedge clk);
        m_step(w, a, d, md, ack, mret, rs);
        #1;
        check("t_intr", t_intr, m_phase == 1);
        check("e_intr", e_intr, m_phase == 2);
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d);
        cyc(0, 1, BASE + 32'(o), d, 3'b010, 0, 0, 0);
    endtask
    task automatic rd(input logic [4:0] o);
        cyc(1, 0, BASE + 32'(o), 32'd0, 3'b010, 0, 0, 0);
    endtask
    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 32'd0, 32'd0, 3'b010, 0, 0, 0);
    endtask
    task automatic do_ack();  cyc(0, 0, 32'd0, 32'd0, 3'b010, 1, 0, 0); endtask
    task automatic do_mret(); cyc(0, 0, 32'd0, 32'd0, 3'b010, 0, 1, 0); endtask
    task automatic do_rst();  cyc(0, 0, 32'd0, 32'd0, 3'b010, 0, 0, 1); endtask

    initial begin
        int lat;
        logic [31:0] o, d;
        logic [2:0]  md;
        irq_lvl = 0;
        m_reset();
        rst = 1; rd_en = 0; wr_en = 0; addr = 0; wdata = 0; mem_mode = 3'b010;
        ext_irq = 0; intr_ack = 0; is_mret = 0;

        // 1: reset values
        do_rst(); do_rst();
        check("rst_t_intr", t_intr, 0);
        check("rst_e_intr", e_intr, 0);
        rd(5'h00); check("rst_mtime_lo", last_rdata, 32'd0);
        rd(5'h04); check("rst_mtime_hi", last_rdata, 32'd0);
        rd(5'h08); check("rst_cmp_lo", last_rdata, 32'hFFFF_FFFF);
        rd(5'h0C); check("rst_cmp_hi", last_rdata, 32'hFFFF_FFFF);
        rd(5'h10); check("rst_ctrl", last_rdata, 32'd0);
        rd(5'h14); check("rst_pend", last_rdata, 32'd0);
        rd(5'h18); rd(5'h1C);

        // 2: timer interrupt, ack, rewrite compare, mret
        wr(5'h08, 32'd5); wr(5'h0C, 32'd0); wr(5'h10, 32'd5);
        for (int i = 0; i < 40 && !t_intr; i++) idle(1);
        check("t_intr_rise", t_intr, 1);
        rd(5'h00);
        check("t_intr_mtime_ge5", last_rdata >= 32'd5, 1);
        do_ack();
        check("t_intr_after_ack", t_intr, 0);
        wr(5'h08, 32'd100);
        do_mret();
        idle(3);
        check("t_intr_after_mret", t_intr, 0);

        // 3: 64-bit carry and write-over-tick
        wr(5'h10, 32'd0); wr(5'h04, 32'd0); wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h10, 32'd4); idle(1);
        rd(5'h04); check("carry_hi", last_rdata, 32'd1);
        wr(5'h00, 32'd7);
        rd(5'h00); check("wr_lo_on_tick", last_rdata, 32'd7);
        rd(5'h04); check("hi_unchanged", last_rdata, 32'd1);

        // 4: external interrupt latency and set-beats-W1C
        do_rst();
        wr(5'h10, 32'd2);
        irq_lvl = 1;
        lat = 0;
        for (int i = 0; i < 12 && !e_intr; i++) begin idle(1); lat++; end
        check("e_intr_rise", e_intr, 1);
        check("e_intr_latency", (lat >= S + 1) && (lat <= S + 2), 1);
        irq_lvl = 0; idle(S + 2);
        irq_lvl = 1; idle(S);
        wr(5'h14, 32'd2);
        rd(5'h14); check("eip_set_wins", last_rdata[1], 1);
        wr(5'h14, 32'd2);
        rd(5'h14); check("eip_w1c", last_rdata[1], 0);
        idle(1);
        check("e_intr_dropped", e_intr, 0);

        // 5: priority, hand-over after mret, byte write ignored
        do_rst(); irq_lvl = 0;
        wr(5'h08, 32'd3); wr(5'h0C, 32'd0); wr(5'h10, 32'd4);
        idle(6); irq_lvl = 1; idle(S + 3);
        wr(5'h10, 32'd7); idle(1);
        check("prio_t", t_intr, 1);
        check("prio_e", e_intr, 0);
        do_ack();
        wr(5'h0C, 32'hFFFF_FFFF);
        do_mret(); idle(2);
        check("handover_e", e_intr, 1);
        check("handover_t", t_intr, 0);
        cyc(0, 1, BASE + 32'h10, 32'd0, 3'b000, 0, 0, 0);
        check("byte_hit", last_hit, 0);
        rd(5'h10); check("byte_no_change", last_rdata, 32'd7);

        // 6: reset while servicing
        do_rst(); irq_lvl = 0;
        wr(5'h08, 32'd7); wr(5'h0C, 32'd0); wr(5'h10, 32'd5);
        for (int i = 0; i < 40 && !t_intr; i++) idle(1);
        check("svc_t_rise", t_intr, 1);
        do_ack();
        wr(5'h10, 32'd1); wr(5'h00, 32'd9);
        rd(5'h00); check("svc_mtime9", last_rdata, 32'd9);
        do_rst();
        check("rst6_t", t_intr, 0);
        check("rst6_e", e_intr, 0);
        rd(5'h00); check("rst6_mtime", last_rdata, 32'd0);
        rd(5'h08); check("rst6_cmp", last_rdata, 32'hFFFF_FFFF);
        rd(5'h10); check("rst6_ctrl", last_rdata, 32'd0);
        rd(5'h14); check("rst6_pend", last_rdata, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            o  = 32'($urandom_range(0, 7)) << 2;
            md = 3'b010;
            case ($urandom_range(0, 15))
                0:       o = o + 32'd1;
                1:       o = 32'h20;
                2:       o = 32'hFFFF_FFFC;
                3:       md = 3'($urandom_range(0, 7));
                default: ;
            endcase
            case (o)
                32'h00:  d = $urandom_range(0, 40);
                32'h08:  d = $urandom_range(0, 80);
                32'h04, 32'h0C: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
                32'h10:  d = {29'd0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3))};
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) irq_lvl = ~irq_lvl;
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), BASE + o, d, md,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 149) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
